// File: rtl/brew_sequencer_if.sv
// Handshake-free control/status bundle between the brew sequencer and its controller.
// master drives the requests and sensors; slave is the sequencer.
interface brew_sequencer_if;
   logic       start;
   logic [1:0] sz;
   logic       sr;
   logic       sp;
   logic       sn;
   logic       vl;
   logic       temp_ok;
   logic       abort;
   logic       clr;
   logic       aq;
   logic       p;
   logic       m;
   logic       busy;
   logic       done;
   logic [3:0] err;
   logic       tmo;
   logic [2:0] state;

   modport master (
      output start, sz, sr, sp, sn, vl, temp_ok, abort, clr,
      input  aq, p, m, busy, done, err, tmo, state
   );

   modport slave (
      input  start, sz, sr, sp, sn, vl, temp_ok, abort, clr,
      output aq, p, m, busy, done, err, tmo, state
   );
endinterface

// File: rtl/brew_sequencer.sv
// Beverage brew FSM (heat, pump, mix, done) with supply/cup fault latching; Moore outputs, one-edge reaction, no backpressure.
// Optional heat-phase timeout enabled by defining BREW_TIMEOUT_EN.
module brew_sequencer #(
   parameter int PUMP_UNIT = 4,
   parameter int MIX_CYC   = 6,
   parameter int HEAT_TMO  = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   brew_sequencer_if.slave  bus
);

   localparam int CNT_MAX = (PUMP_UNIT * 5 > MIX_CYC) ? PUMP_UNIT * 5 : MIX_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HEAT  = 3'd1,
      S_PUMP  = 3'd2,
      S_MIX   = 3'd3,
      S_DONE  = 3'd4,
      S_FAULT = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      sz_q, sz_d;
   logic [3:0]      err_q, err_d;
   logic            tmo_q, tmo_d;
   logic [CW-1:0]   pump_load;
   logic [CW-1:0]   mix_load;

`ifdef BREW_TIMEOUT_EN
   localparam int HW = $clog2(HEAT_TMO + 1);
   logic [HW-1:0]   heat_q, heat_d;
`endif

   assign pump_load = CW'(PUMP_UNIT * (2 + int'(sz_q)) - 1);
   assign mix_load  = CW'(MIX_CYC - 1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sz_d    = sz_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
`ifdef BREW_TIMEOUT_EN
      heat_d  = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.sr && bus.sp && bus.sn && bus.vl) begin
                  state_d = S_HEAT;
                  sz_d    = bus.sz;
               end else begin
                  state_d = S_FAULT;
                  err_d   = {~bus.vl, ~bus.sn, ~bus.sp, ~bus.sr};
               end
            end
         end
         // Abort outranks every other exit from the active phases.
         S_HEAT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (bus.temp_ok) begin
               state_d = S_PUMP;
               cnt_d   = pump_load;
`ifdef BREW_TIMEOUT_EN
            end else if (heat_q == HW'(HEAT_TMO - 1)) begin
               state_d = S_FAULT;
               tmo_d   = 1'b1;
               err_d   = 4'b0000;
            end else begin
               heat_d  = heat_q + 1'b1;
`endif
            end
         end
         S_PUMP: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (!bus.vl) begin
               state_d = S_FAULT;
               err_d   = 4'b1000;
            end else if (cnt_q == '0) begin
               state_d = S_MIX;
               cnt_d   = mix_load;
            end else begin
               cnt_d   = cnt_q - 1'b1;
            end
         end
         S_MIX: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (!bus.vl) begin
               state_d = S_FAULT;
               err_d   = 4'b1000;
            end else if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_FAULT: begin
            if (bus.clr) begin
               state_d = S_IDLE;
               err_d   = 4'b0000;
               tmo_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sz_q    <= 2'b00;
         err_q   <= 4'b0000;
         tmo_q   <= 1'b0;
`ifdef BREW_TIMEOUT_EN
         heat_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sz_q    <= sz_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
`ifdef BREW_TIMEOUT_EN
         heat_q  <= heat_d;
`endif
      end
   end

   // Outputs decode straight from flops so reset clears them without a clock.
   assign bus.aq    = (state_q == S_HEAT);
   assign bus.p     = (state_q == S_PUMP);
   assign bus.m     = (state_q == S_MIX);
   assign bus.busy  = (state_q == S_HEAT) || (state_q == S_PUMP) || (state_q == S_MIX);
   assign bus.done  = (state_q == S_DONE);
   assign bus.err   = err_q;
   assign bus.state = state_q;
`ifdef BREW_TIMEOUT_EN
   assign bus.tmo   = tmo_q;
`else
   assign bus.tmo   = 1'b0;
`endif

endmodule

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 The block SHALL provide parameter PUMP_UNIT, default 4: pump cycles per size step; pump time = PUMP_UNIT*(2+SZ).
REQ-002 The block SHALL provide parameter MIX_CYC, default 6: mixer-on duration in cycles.
REQ-003 The block SHALL provide parameter HEAT_TMO, default 64: heat-phase cycle limit, used only with BREW_TIMEOUT_EN.
REQ-004 The block SHALL provide the following ports:
- CLK  in  1  single clock, rising edge; one clock.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  brew request, level-sampled in IDLE.
- SZ  in  2  cup size, {B1,B0}, latched on accepted START.
- SR, SP, SN  in  1 each  water, powder, sugar supply OK.
- VL  in  1  cup present.
- TEMP_OK  in  1  water at brew temperature.
- ABORT  in  1  cancel active brew.
- CLR  in  1  clear FAULT.
- AQ  out  1  heater enable.
- P  out  1  pump enable.
- M  out  1  mixer enable.
- BUSY  out  1  high in HEAT, PUMP, MIX.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  4  fault cause {~VL,~SN,~SP,~SR}, latched.
- TMO  out  1  heat timeout flag.
- STATE  out  3  current state code.

Function
REQ-005 The FSM SHALL use state codes IDLE=0, HEAT=1, PUMP=2, MIX=3, DONE=4, FAULT=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-006 All outputs SHALL be registered Moore outputs decoded from the state, ERR and TMO: AQ only in HEAT, P only in PUMP, M only in MIX, DONE only in DONE.
REQ-007 In IDLE with START=1:
- SR&SP&SN&VL=1: go to HEAT at the next edge and latch SZ.
- Otherwise: go to FAULT with ERR={~VL,~SN,~SP,~SR} sampled that cycle.
REQ-008 In HEAT, TEMP_OK=1 SHALL cause a transition to PUMP and load the cycle counter with PUMP_UNIT*(2+SZ_latched)-1.
REQ-009 In PUMP the counter SHALL decrement each cycle; at 0 the FSM SHALL go to MIX and load MIX_CYC-1.
REQ-010 P high time SHALL be exactly 8/12/16/20 cycles for SZ=00/01/10/11 at default PUMP_UNIT.
REQ-011 In MIX the counter SHALL decrement each cycle; at 0 the FSM SHALL go to DONE.
REQ-012 DONE SHALL last exactly one cycle and then return to IDLE; START is not re-sampled until IDLE.
REQ-013 In PUMP or MIX, VL=0 SHALL go to FAULT with ERR=4'b1000; this wins over counter expiry in the same cycle.
REQ-014 In HEAT, PUMP or MIX, ABORT=1 SHALL go to IDLE with ERR unchanged; ABORT wins over TEMP_OK, counter expiry and VL loss.
REQ-015 START in any state other than IDLE SHALL be ignored; SZ changes after latching SHALL have no effect.
REQ-016 In FAULT, CLR=1 SHALL go to IDLE and zero ERR and TMO; START in the same cycle SHALL be ignored.
REQ-017 FAULT SHALL hold with all actuators off until CLR.
REQ-018 Counter width SHALL cover PUMP_UNIT*5 and MIX_CYC without overflow.

Reset
REQ-019 RST_N=0 SHALL immediately force state IDLE, counter 0, latched SZ 00, and AQ=P=M=BUSY=DONE=TMO=0, ERR=0, STATE=0.
REQ-020 Reset asserted mid-brew SHALL drop all actuators within the same reset assertion, without waiting for a clock edge.
REQ-021 After RST_N rises, the first state change SHALL occur on a CLK edge.

Configuration
REQ-022 With BREW_TIMEOUT_EN defined, a HEAT-cycle counter SHALL run; HEAT_TMO cycles in HEAT without TEMP_OK SHALL go to FAULT with TMO=1 and ERR=0.
REQ-023 With BREW_TIMEOUT_EN defined, the counter SHALL restart on each HEAT entry, and TEMP_OK on the limit cycle SHALL win.
REQ-024 Without BREW_TIMEOUT_EN, HEAT SHALL wait indefinitely and TMO SHALL be tied 0.

Verification
REQ-025 Full brew: all sensors 1, START=1, SZ=10, TEMP_OK rising 5 cycles later -> AQ high 5 cycles, P high 16 cycles, M high 6 cycles, DONE pulse 1 cycle, then IDLE.
REQ-026 Missing supply: SP=0, SN=0 at START -> FAULT, ERR=4'b0110, no actuator ever high; CLR=1 -> IDLE, ERR=0.
REQ-027 Cup removed: VL=0 on the 3rd PUMP cycle with SZ=00 -> P drops next edge, FAULT, ERR=4'b1000.
REQ-028 Abort: ABORT=1 with TEMP_OK=1 in the same HEAT cycle -> IDLE, P never asserted, no DONE.
REQ-029 Timeout (BREW_TIMEOUT_EN): TEMP_OK held 0 -> FAULT after 64 HEAT cycles, TMO=1; rebuilt without the macro -> remains in HEAT after 200 cycles.
REQ-030 Async reset: RST_N=0 mid-MIX between clock edges -> M=0 and STATE=0 immediately.
